// File: rtl/seek_f_sched_pkg.sv
// Shared encodings and defaults for the seek_f request scheduler.
`ifndef Datawidth
`define Datawidth 16
`endif
`define SEEK_F_FW (`Datawidth+3)

package seek_f_sched_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int TMO_DEFAULT = 8;
    localparam int FW_DEFAULT  = `SEEK_F_FW;
endpackage

// File: rtl/seek_f_sched_rr_arb.sv
// Round-robin priority picker: first asserted request at or after ptr, wrapping.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    always_comb begin
        int          j;
        logic [IW-1:0] jj;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IW'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end
endmodule

// File: rtl/seek_f_sched.sv
// Shares one seek_f unit among NREQ requesters: round-robin accept, one-cycle
// issue, bounded wait for the result, then a tagged response with backpressure.
//   state   | meaning
//   S_IDLE  | arbitrate, accept one request
//   S_ISSUE | u_en pulse with latched operands
//   S_WAIT  | wait for u_rdy or timeout
//   S_RESP  | hold response until rsp_ready
module seek_f_sched
    import seek_f_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = `Datawidth,
    parameter int TMO  = TMO_DEFAULT,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_c,
    input  logic [NREQ*DW-1:0]   req_e,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [DW+2:0]        rsp_f,
    output logic                 rsp_err,
    output logic                 u_en,
    output logic [DW-1:0]        u_c,
    output logic [DW-1:0]        u_e,
    input  logic [DW+2:0]        u_f,
    input  logic                 u_rdy,
    output logic [15:0]          done_cnt,
    output logic                 spur_err
);
    localparam int CW = $clog2(TMO);

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [DW-1:0]   c_q, c_d, e_q, e_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW+2:0]   f_q, f_d;
    logic            err_q, err_d;
    logic [15:0]     done_q, done_d;
    logic            spur_q, spur_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        c_d      = c_q;
        e_d      = e_q;
        cnt_d    = cnt_q;
        f_d      = f_q;
        err_d    = err_q;
        done_d   = done_q;
        spur_d   = spur_q | (u_rdy && (state_q != S_WAIT));
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    c_d      = req_c[arb_idx*DW +: DW];
                    e_d      = req_e[arb_idx*DW +: DW];
                    id_d     = arb_idx;
                    rr_ptr_d = (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // u_f is only nonzero while u_rdy is high, so capture it now
                if (u_rdy) begin
                    f_d     = u_f;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TMO-1)) begin
                    f_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    if (!err_q && (done_q != 16'hFFFF)) done_d = done_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            c_q      <= '0;
            e_q      <= '0;
            cnt_q    <= '0;
            f_q      <= '0;
            err_q    <= 1'b0;
            done_q   <= '0;
            spur_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            c_q      <= c_d;
            e_q      <= e_d;
            cnt_q    <= cnt_d;
            f_q      <= f_d;
            err_q    <= err_d;
            done_q   <= done_d;
            spur_q   <= spur_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) ? arb_gnt : '0;
    assign u_en      = (state_q == S_ISSUE);
    assign u_c       = c_q;
    assign u_e       = e_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_f     = f_q;
    assign rsp_err   = err_q;
    assign done_cnt  = done_q;
    assign spur_err  = spur_q;
endmodule

// File: tb/tb_seek_f_sched.sv
// Directed table plus randomized jobs for seek_f_sched against a seek_f stub
// with programmable result latency.
module tb_seek_f_sched;
    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int TMO  = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NREQ-1:0]  req_valid = '0;
    logic [NREQ*DW-1:0] req_c = '0;
    logic [NREQ*DW-1:0] req_e = '0;
    logic [NREQ-1:0]  req_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [1:0]       rsp_id;
    logic [DW+2:0]    rsp_f;
    logic             rsp_err;
    logic             u_en;
    logic [DW-1:0]    u_c, u_e;
    logic [DW+2:0]    u_f = '0;
    logic             u_rdy = 1'b0;
    logic [15:0]      done_cnt;
    logic             spur_err;

    seek_f_sched #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_c(req_c), .req_e(req_e), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_f(rsp_f), .rsp_err(rsp_err),
        .u_en(u_en), .u_c(u_c), .u_e(u_e), .u_f(u_f), .u_rdy(u_rdy),
        .done_cnt(done_cnt), .spur_err(spur_err)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    int            m_ptr = 0;
    int            m_done = 0;
    logic          m_spur = 1'b0;
    int            stub_lat = 0;
    logic [DW+2:0] stub_f = '0;
    logic          force_rdy = 1'b0;
    int            pend = 0;
    time           last_acc = 0;

    // seek_f stub: result appears stub_lat cycles after the en cycle (0 = never)
    always @(negedge clk) begin
        u_rdy = force_rdy;
        u_f   = '0;
        if (reset) pend = 0;
        else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    u_rdy = 1'b1;
                    u_f   = stub_f;
                end
            end
            if (u_en && stub_lat > 0) pend = stub_lat;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_valid", rsp_valid, 0);
            chk("idle_en", u_en, 0);
            chk("idle_ready", req_ready, 0);
        end
    endtask

    // Starts and ends at posedge+1 of an IDLE cycle.
    task automatic run_job(input logic [3:0] vld, input logic [63:0] cs, input logic [63:0] es,
                           input logic [15:0] ec, input logic [15:0] ee, input int lat, input int bp,
                           input logic [18:0] f, input int exp_g, input logic [18:0] exp_f,
                           input logic exp_err, input bit gap);
        int  n;
        bit  seen;
        time t;
        req_valid = vld; req_c = cs; req_e = es;
        stub_lat = lat; stub_f = f; rsp_ready = 1'b0;
        #1;
        chk("accept_ready", req_ready, 4'b1 << exp_g);
        t = $time;
        if (gap) chk("rr_gap", 32'(t - last_acc), 40);
        last_acc = t;
        @(posedge clk); #2;
        chk("issue_en", u_en, 1);
        chk("issue_c", u_c, ec);
        chk("issue_e", u_e, ee);
        chk("issue_ready", req_ready, 0);
        n = 0; seen = 0;
        while (!seen && n < TMO + 4) begin
            @(posedge clk); #2;
            n++;
            if (rsp_valid) seen = 1;
            else begin
                chk("wait_en", u_en, 0);
                chk("wait_ops", {u_c, u_e}, {ec, ee});
            end
        end
        chk("rsp_seen", seen, 1);
        if (!seen) return;
        chk("wait_cycles", n - 1, (lat == 0) ? TMO : lat);
        chk("rsp_id", rsp_id, exp_g);
        chk("rsp_f", rsp_f, exp_f);
        chk("rsp_err", rsp_err, exp_err);
        chk("spur_err", spur_err, m_spur);
        for (int i = 0; i < bp; i++) begin
            req_valid = 4'hF;
            @(posedge clk); #2;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_f", rsp_f, exp_f);
            chk("bp_id", rsp_id, exp_g);
            chk("bp_ready", req_ready, 0);
            chk("bp_en", u_en, 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (!exp_err) m_done++;
        chk("rsp_drop", rsp_valid, 0);
        chk("done_cnt", done_cnt, m_done);
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] c;
        logic [15:0] e;
        int          lat;
        int          bp;
        logic [18:0] f;
        int          exp_g;
        logic [18:0] exp_f;
        logic        exp_err;
        bit          gap;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] cs, es;
        logic [3:0]  vld;
        int          g, lat, r;
        logic [18:0] f;

        vecs[0]  = '{4'hF,    16'h1000, 16'h0001, 1, 0, 19'h11111, 0, 19'h11111, 1'b0, 1'b0};
        vecs[1]  = '{4'hF,    16'h1001, 16'h0002, 1, 0, 19'h12222, 1, 19'h12222, 1'b0, 1'b1};
        vecs[2]  = '{4'hF,    16'h1002, 16'h0003, 1, 0, 19'h13333, 2, 19'h13333, 1'b0, 1'b1};
        vecs[3]  = '{4'hF,    16'h1003, 16'h0004, 1, 0, 19'h14444, 3, 19'h14444, 1'b0, 1'b1};
        vecs[4]  = '{4'hF,    16'h1004, 16'h0005, 1, 0, 19'h15555, 0, 19'h15555, 1'b0, 1'b1};
        vecs[5]  = '{4'b0010, 16'h6000, 16'h2005, 1, 0, 19'h2A5A5, 1, 19'h2A5A5, 1'b0, 1'b0};
        vecs[6]  = '{4'b0001, 16'hBEEF, 16'h0F0F, 1, 5, 19'h7ABCD, 0, 19'h7ABCD, 1'b0, 1'b0};
        vecs[7]  = '{4'b0100, 16'h1234, 16'h5678, 0, 0, 19'h3FFFF, 2, 19'h00000, 1'b1, 1'b0};
        vecs[8]  = '{4'b1001, 16'hAAAA, 16'h5555, 2, 1, 19'h00042, 3, 19'h00042, 1'b0, 1'b0};
        vecs[9]  = '{4'b1001, 16'hFFFF, 16'h0000, 8, 0, 19'h7FFFF, 0, 19'h7FFFF, 1'b0, 1'b0};
        vecs[10] = '{4'b0110, 16'h0101, 16'h8080, 3, 2, 19'h40001, 1, 19'h40001, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", {req_ready, rsp_valid, rsp_id, rsp_f, rsp_err, u_en, u_c, u_e,
                           done_cnt, spur_err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            cs = {$urandom, $urandom};
            es = {$urandom, $urandom};
            cs[vecs[i].exp_g*16 +: 16] = vecs[i].c;
            es[vecs[i].exp_g*16 +: 16] = vecs[i].e;
            run_job(vecs[i].vld, cs, es, vecs[i].c, vecs[i].e, vecs[i].lat, vecs[i].bp,
                    vecs[i].f, vecs[i].exp_g, vecs[i].exp_f, vecs[i].exp_err, vecs[i].gap);
        end
        m_ptr = 2;
        idle(3);

        // spurious u_rdy while idle
        force_rdy = 1'b1;
        @(posedge clk); #1;
        force_rdy = 1'b0;
        #1;
        chk("spur_set", spur_err, 1);
        m_spur = 1'b1;
        idle(3);
        chk("spur_hold", spur_err, 1);

        for (int i = 0; i < 40; i++) begin
            vld = 4'($urandom_range(1, 15));
            g   = model_grant(vld, m_ptr);
            r   = $urandom_range(0, 9);
            lat = (r > TMO) ? 0 : r;
            f   = 19'($urandom);
            cs  = {$urandom, $urandom};
            es  = {$urandom, $urandom};
            run_job(vld, cs, es, cs[g*16 +: 16], es[g*16 +: 16], lat, $urandom_range(0, 3),
                    f, g, (lat == 0) ? 19'h0 : f, lat == 0, 1'b0);
            m_ptr = (g + 1) % NREQ;
            if ($urandom_range(0, 3) == 0) idle(2);
        end

        // leave rr_ptr at 1, then reset in the middle of a timing-out job
        run_job(4'b0001, 64'h0, 64'h0, 16'h0, 16'h0, 1, 0, 19'h00007, 0, 19'h00007, 1'b0, 1'b0);
        req_valid = 4'b0100;
        req_c = {$urandom, $urandom};
        req_e = {$urandom, $urandom};
        stub_lat = 0;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("reset_mid_outs", {req_ready, rsp_valid, rsp_id, rsp_f, rsp_err, u_en, u_c, u_e,
                               done_cnt, spur_err}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_ptr = 0; m_done = 0; m_spur = 1'b0;
        idle(4);
        run_job(4'hF, 64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555, 16'h1111, 16'h5555,
                1, 0, 19'h0ABCD, 0, 19'h0ABCD, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
